// File: rtl/l80_pkg.sv
// rtl/l80_pkg.sv - shared command codes, response codes and loader state encoding
`timescale 1ns/1ps
// Purpose: constants and types shared by serial_loader and loader_txq.
// Contents: host command bytes, ACK/NAK bytes, loader state enum, len decode helper.
package l80_pkg;

    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] CMD_READ  = 8'h52;
    localparam logic [7:0] CMD_GO    = 8'h47;
    localparam logic [7:0] CMD_HOLD  = 8'h48;

    localparam logic [7:0] RSP_ACK   = 8'h06;
    localparam logic [7:0] RSP_NAK   = 8'h15;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_AH,
        ST_AL,
        ST_LEN,
        ST_WDATA,
        ST_WSUM,
        ST_RADDR,
        ST_RWAIT,
        ST_RSEND,
        ST_RSUM,
        ST_ACK,
        ST_NAK
    } state_t;

    // A length byte of zero stands for a full 256-byte transfer.
    function automatic logic [8:0] len_to_count(input logic [7:0] len);
        return (len == 8'h00) ? 9'd256 : {1'b0, len};
    endfunction

endpackage

// File: rtl/loader_txq.sv
// rtl/loader_txq.sv - one-byte transmit holding register with tx_valid/tx_busy handshake
`timescale 1ns/1ps
// Purpose: accepts one byte via load/data when ready, then pulses tx_valid for one
// cycle once the transmitter is idle. The cycle after a pulse never launches, since
// the transmitter may not have raised tx_busy yet.
// Ports:
//   clock, RESET_n   system clock, asynchronous active-low reset
//   load, data       write a byte into the holding register (only when ready)
//   ready            holding register empty
//   tx_data/tx_valid byte and one-cycle strobe towards the uart
//   tx_busy          uart transmitter busy
module loader_txq (
    input  logic       clock,
    input  logic       RESET_n,
    input  logic       load,
    input  logic [7:0] data,
    output logic       ready,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_busy
);

    logic       full;
    logic [7:0] hold;
    logic       guard;
    logic       launch;

    // tx_valid blocks the decision during the pulse cycle, guard blocks the
    // following one; only after that is tx_busy trusted.
    assign launch = full && !tx_valid && !guard && !tx_busy;
    assign ready  = !full;

    always_ff @(posedge clock or negedge RESET_n) begin
        if (!RESET_n) begin
            full     <= 1'b0;
            hold     <= 8'h00;
            guard    <= 1'b0;
            tx_valid <= 1'b0;
            tx_data  <= 8'h00;
        end else begin
            tx_valid <= launch;
            guard    <= tx_valid;
            if (launch) begin
                tx_data <= hold;
                full    <= 1'b0;
            end
            if (load) begin
                hold <= data;
                full <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/serial_loader.sv
// rtl/serial_loader.sv - UART-driven RAM loader and CPU hold control for the light8080 SOC
`timescale 1ns/1ps
// Purpose: decodes host byte frames (cmd, addr_hi, addr_lo, len, data) from the uart
// receiver, writes or reads RAM directly and answers through loader_txq.
// Optional feature macro: SERIAL_LOADER_CHECKSUM_EN adds a trailing checksum byte to
// 'W' frames and to 'R' responses.
// Ports:
//   clock, RESET_n        system clock, asynchronous active-low reset
//   rx_data, rx_valid     received byte and strobe
//   tx_data, tx_valid     transmit byte and strobe; tx_busy from the transmitter
//   mem_addr, mem_we,     RAM port (synchronous read, one cycle latency)
//   mem_wdata, mem_rdata
//   cpu_hold              1 keeps the CPU in reset and grants RAM to this block
//   busy                  high whenever the command FSM is not idle
module serial_loader
    import l80_pkg::*;
#(
    parameter int ADDR_W        = 13,
    parameter int TIMEOUT_CYC   = 2700000,
    parameter bit HOLD_AT_RESET = 1'b0
) (
    input  logic              clock,
    input  logic              RESET_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic              cpu_hold,
    output logic              busy
);

    localparam int TW = ($clog2(TIMEOUT_CYC) > 0) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0]     TLIM     = TW'(TIMEOUT_CYC - 1);
    localparam logic [TW-1:0]     TONE     = TW'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    state_t              state, state_n;
    logic [7:0]          cmd, cmd_n;
    logic [7:0]          ahi, ahi_n;
    logic [ADDR_W-1:0]   addr, addr_n;
    logic [8:0]          count, count_n;
    logic [TW-1:0]       timer, timer_n;
    logic [7:0]          sum, sum_n;
    logic [7:0]          rd_byte, rd_byte_n;
    logic                cpu_hold_n;
    logic                mem_we_n;
    logic [ADDR_W-1:0]   mem_addr_n;
    logic [7:0]          mem_wdata_n;
    logic                tx_load;
    logic [7:0]          tx_byte;
    logic                tx_ready;
    logic                rx_state;
    logic [15:0]         host_addr;
`ifdef SERIAL_LOADER_CHECKSUM_EN
    logic [7:0]          wsum;
`endif

    loader_txq u_txq (
        .clock    (clock),
        .RESET_n  (RESET_n),
        .load     (tx_load),
        .data     (tx_byte),
        .ready    (tx_ready),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_busy  (tx_busy)
    );

    assign busy = (state != ST_IDLE);

    always_ff @(posedge clock or negedge RESET_n) begin
        if (!RESET_n) begin
            state     <= ST_IDLE;
            cmd       <= 8'h00;
            ahi       <= 8'h00;
            addr      <= '0;
            count     <= 9'd0;
            timer     <= '0;
            sum       <= 8'h00;
            rd_byte   <= 8'h00;
            cpu_hold  <= HOLD_AT_RESET;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 8'h00;
        end else begin
            state     <= state_n;
            cmd       <= cmd_n;
            ahi       <= ahi_n;
            addr      <= addr_n;
            count     <= count_n;
            timer     <= timer_n;
            sum       <= sum_n;
            rd_byte   <= rd_byte_n;
            cpu_hold  <= cpu_hold_n;
            mem_we    <= mem_we_n;
            mem_addr  <= mem_addr_n;
            mem_wdata <= mem_wdata_n;
        end
    end

    always_comb begin
        state_n     = state;
        cmd_n       = cmd;
        ahi_n       = ahi;
        addr_n      = addr;
        count_n     = count;
        timer_n     = timer;
        sum_n       = sum;
        rd_byte_n   = rd_byte;
        cpu_hold_n  = cpu_hold;
        mem_we_n    = 1'b0;
        mem_addr_n  = mem_addr;
        mem_wdata_n = mem_wdata;
        tx_load     = 1'b0;
        tx_byte     = 8'h00;
        host_addr   = {ahi, rx_data};
`ifdef SERIAL_LOADER_CHECKSUM_EN
        wsum        = sum + rx_data;
`endif
        rx_state    = (state == ST_AH) || (state == ST_AL) || (state == ST_LEN) ||
                      (state == ST_WDATA) || (state == ST_WSUM);

        // Inter-byte watchdog for every state that is waiting on the host.
        if (rx_state) begin
            if (rx_valid) begin
                timer_n = '0;
            end else if (timer == TLIM) begin
                timer_n = '0;
                state_n = ST_IDLE;
            end else begin
                timer_n = timer + TONE;
            end
        end

        case (state)
            ST_IDLE: begin
                if (rx_valid) begin
                    cmd_n   = rx_data;
                    timer_n = '0;
                    case (rx_data)
                        CMD_WRITE, CMD_READ: state_n = ST_AH;
                        CMD_GO:              state_n = ST_ACK;
                        CMD_HOLD: begin
                            cpu_hold_n = 1'b1;
                            state_n    = ST_ACK;
                        end
                        default:             state_n = ST_NAK;
                    endcase
                end
            end
            ST_AH: begin
                if (rx_valid) begin
                    ahi_n   = rx_data;
                    state_n = ST_AL;
                end
            end
            ST_AL: begin
                if (rx_valid) begin
                    addr_n  = host_addr[ADDR_W-1:0];
                    state_n = ST_LEN;
                end
            end
            ST_LEN: begin
                if (rx_valid) begin
                    count_n = len_to_count(rx_data);
                    sum_n   = 8'h00;
                    if (cmd == CMD_WRITE) begin
                        state_n = ST_WDATA;
                    end else if (cpu_hold) begin
                        mem_addr_n = addr;
                        state_n    = ST_RADDR;
                    end else begin
                        state_n = ST_NAK;
                    end
                end
            end
            ST_WDATA: begin
                if (rx_valid) begin
                    // Without the RAM grant the bytes are swallowed so the frame
                    // still ends cleanly before the NAK.
                    if (cpu_hold) begin
                        mem_we_n    = 1'b1;
                        mem_addr_n  = addr;
                        mem_wdata_n = rx_data;
                    end
                    addr_n  = addr + ADDR_ONE;
                    count_n = count - 9'd1;
                    sum_n   = sum + rx_data;
                    if (count == 9'd1) begin
`ifdef SERIAL_LOADER_CHECKSUM_EN
                        state_n = ST_WSUM;
`else
                        state_n = cpu_hold ? ST_ACK : ST_NAK;
`endif
                    end
                end
            end
`ifdef SERIAL_LOADER_CHECKSUM_EN
            ST_WSUM: begin
                if (rx_valid) begin
                    state_n = (cpu_hold && (wsum == 8'h00)) ? ST_ACK : ST_NAK;
                end
            end
`endif
            ST_RADDR: begin
                state_n = ST_RWAIT;
            end
            ST_RWAIT: begin
                rd_byte_n = mem_rdata;
                state_n   = ST_RSEND;
            end
            ST_RSEND: begin
                if (tx_ready) begin
                    tx_load = 1'b1;
                    tx_byte = rd_byte;
                    sum_n   = sum + rd_byte;
                    addr_n  = addr + ADDR_ONE;
                    count_n = count - 9'd1;
                    if (count == 9'd1) begin
`ifdef SERIAL_LOADER_CHECKSUM_EN
                        state_n = ST_RSUM;
`else
                        state_n = ST_IDLE;
`endif
                    end else begin
                        mem_addr_n = addr + ADDR_ONE;
                        state_n    = ST_RADDR;
                    end
                end
            end
`ifdef SERIAL_LOADER_CHECKSUM_EN
            ST_RSUM: begin
                if (tx_ready) begin
                    tx_load = 1'b1;
                    tx_byte = 8'h00 - sum;
                    state_n = ST_IDLE;
                end
            end
`endif
            ST_ACK: begin
                if (tx_ready) begin
                    tx_load = 1'b1;
                    tx_byte = RSP_ACK;
                    // 'G' releases the CPU together with queueing its ACK.
                    if (cmd == CMD_GO) begin
                        cpu_hold_n = 1'b0;
                    end
                    state_n = ST_IDLE;
                end
            end
            ST_NAK: begin
                if (tx_ready) begin
                    tx_load = 1'b1;
                    tx_byte = RSP_NAK;
                    state_n = ST_IDLE;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_serial_loader.sv
// tb/tb_serial_loader.sv - self-checking bench for serial_loader
`timescale 1ns/1ps
module tb_serial_loader;

    localparam int AW    = 13;
    localparam int TO    = 40;
    localparam int DEPTH = 1 << AW;

    logic          clock = 1'b0;
    logic          RESET_n = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_valid = 1'b0;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_busy;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [7:0]    mem_wdata;
    logic [7:0]    mem_rdata;
    logic          cpu_hold;
    logic          busy;

    int n_cmp  = 0;
    int n_fail = 0;

    serial_loader #(.ADDR_W(AW), .TIMEOUT_CYC(TO), .HOLD_AT_RESET(1'b0)) dut (
        .clock     (clock),
        .RESET_n   (RESET_n),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_busy   (tx_busy),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .cpu_hold  (cpu_hold),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    function automatic logic [7:0] pat(input int i);
        return 8'((i * 37 + 11) ^ (i >> 8));
    endfunction

    // Synchronous RAM seen by the DUT.
    logic [7:0] ram [DEPTH];
    logic       init_req = 1'b0;
    always @(posedge clock) begin
        if (init_req) begin
            for (int i = 0; i < DEPTH; i++) ram[i] <= pat(i);
        end else if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
        end
        mem_rdata <= ram[mem_addr];
    end

    // UART transmitter stand-in: busy rises two cycles after a pulse.
    int   busy_cnt = 0;
    logic start_d  = 1'b0;
    always @(posedge clock) begin
        start_d <= tx_valid;
        if (start_d) busy_cnt <= $urandom_range(1, 4);
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    end
    assign tx_busy = (busy_cnt != 0);

    // Host side receive capture and protocol watch.
    logic [7:0] rxq[$];
    int   hs_viol = 0;
    int   we_viol = 0;
    int   we_cnt  = 0;
    logic prev_v  = 1'b0;
    always @(negedge clock) begin
        if (RESET_n) begin
            if (tx_valid) begin
                rxq.push_back(tx_data);
                if (tx_busy || prev_v) hs_viol++;
            end
            if (mem_we && !cpu_hold) we_viol++;
            if (mem_we) we_cnt++;
        end
        prev_v = tx_valid;
    end

    // Reference model state.
    logic [7:0] exp_ram [DEPTH];
    logic       m_hold = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_now(input logic [7:0] b);
        @(posedge clock);
        #1 rx_data = b;
        rx_valid = 1'b1;
        @(posedge clock);
        #1 rx_valid = 1'b0;
        rx_data = 8'($urandom);
    endtask

    task automatic send_byte(input logic [7:0] b);
        repeat ($urandom_range(0, 2)) @(posedge clock);
        send_now(b);
    endtask

    task automatic expect_resp(input string tag, input logic [7:0] exp[$]);
        int t = 0;
        while (rxq.size() < exp.size() && t < 20000) begin
            @(negedge clock);
            t++;
        end
        repeat (12) @(negedge clock);
        check({tag, "_count"}, rxq.size(), exp.size());
        for (int i = 0; i < exp.size() && i < rxq.size(); i++) check(tag, rxq[i], exp[i]);
        rxq.delete();
    endtask

    task automatic expect1(input string tag, input logic [7:0] b);
        logic [7:0] q[$];
        q.push_back(b);
        expect_resp(tag, q);
    endtask

    task automatic do_write(input int a, input int len, input logic [7:0] d[$]);
        logic [7:0] s = 8'h00;
        int n = (len == 0) ? 256 : len;
        int wa;
        send_byte(8'h57);
        send_byte(8'(a >> 8));
        send_byte(8'(a));
        send_byte(8'(len));
        for (int i = 0; i < n; i++) begin
            send_byte(d[i]);
            s = s + d[i];
            wa = (a + i) % DEPTH;
            if (m_hold) begin
                check("wr_we", mem_we, 1);
                check("wr_addr", mem_addr, wa);
                check("wr_data", mem_wdata, d[i]);
                exp_ram[wa] = d[i];
            end else begin
                check("wr_we_blocked", mem_we, 0);
            end
        end
`ifdef SERIAL_LOADER_CHECKSUM_EN
        send_byte(8'h00 - s);
`endif
        expect1("wr_resp", m_hold ? 8'h06 : 8'h15);
    endtask

    task automatic do_read(input int a, input int len);
        logic [7:0] q[$];
        logic [7:0] s = 8'h00;
        int n = (len == 0) ? 256 : len;
        send_byte(8'h52);
        send_byte(8'(a >> 8));
        send_byte(8'(a));
        send_byte(8'(len));
        if (m_hold) begin
            for (int i = 0; i < n; i++) begin
                q.push_back(exp_ram[(a + i) % DEPTH]);
                s = s + exp_ram[(a + i) % DEPTH];
            end
`ifdef SERIAL_LOADER_CHECKSUM_EN
            q.push_back(8'h00 - s);
`endif
        end else begin
            q.push_back(8'h15);
        end
        expect_resp("rd_resp", q);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_tx_valid"}, tx_valid, 0);
        check({tag, "_tx_data"}, tx_data, 0);
        check({tag, "_mem_we"}, mem_we, 0);
        check({tag, "_mem_addr"}, mem_addr, 0);
        check({tag, "_mem_wdata"}, mem_wdata, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_cpu_hold"}, cpu_hold, 0);
    endtask

    initial begin
        logic [7:0] wd[$];
        int a, len, we_before, mism;

        for (int i = 0; i < DEPTH; i++) exp_ram[i] = pat(i);
        #1;
        check_reset_vals("rst");
        init_req = 1'b1;
        @(posedge clock);
        #1 init_req = 1'b0;
        repeat (2) @(posedge clock);
        #1 RESET_n = 1'b1;

        // Take the RAM.
        send_byte(8'h48);
        m_hold = 1'b1;
        expect1("hold_ack", 8'h06);
        check("hold_set", cpu_hold, 1);

        // Write then read.
        wd.delete();
        wd.push_back(8'hAA); wd.push_back(8'hBB); wd.push_back(8'hCC);
        do_write(16'h0010, 3, wd);
        check("ram_10", ram[16'h10], 8'hAA);
        check("ram_11", ram[16'h11], 8'hBB);
        check("ram_12", ram[16'h12], 8'hCC);
        do_read(16'h0010, 3);

        // Wrap at the top of RAM.
        wd.delete();
        wd.push_back(8'h11); wd.push_back(8'h22);
        do_write(16'h1FFF, 2, wd);
        check("ram_1fff", ram[13'h1FFF], 8'h11);
        check("ram_0000", ram[0], 8'h22);

        // Full-length read.
        do_read(16'h0000, 0);

        // Randomized frames; host address bits above ADDR_W must be ignored.
        for (int k = 0; k < 6; k++) begin
            a   = $urandom_range(0, 65535);
            len = $urandom_range(1, 12);
            wd.delete();
            for (int i = 0; i < len; i++) wd.push_back(8'($urandom));
            do_write(a, len, wd);
            do_read(a ^ 16'hE000, len);
        end

        // Stray byte during a read response is dropped.
        send_byte(8'h52); send_byte(8'h00); send_byte(8'h10); send_byte(8'h01);
        send_now(8'h5A);
        begin
            logic [7:0] q[$];
            q.push_back(exp_ram[16'h10]);
`ifdef SERIAL_LOADER_CHECKSUM_EN
            q.push_back(8'h00 - exp_ram[16'h10]);
`endif
            expect_resp("stray", q);
        end

        // Unknown command.
        send_byte(8'h5A);
        expect1("bad_cmd", 8'h15);

        // Timeout mid-write.
        send_byte(8'h57); send_byte(8'h00); send_byte(8'h00); send_byte(8'h02);
        send_byte(8'h01);
        exp_ram[0] = 8'h01;
        repeat (TO - 1) @(posedge clock);
        #1 check("to_busy_before", busy, 1);
        @(posedge clock);
        #1 check("to_busy_after", busy, 0);
        repeat (10) @(posedge clock);
        check("to_silent", rxq.size(), 0);
        check("to_ram0", ram[0], 8'h01);
        do_read(16'h0000, 1);

        // Release the CPU, then writes/reads are refused.
        send_byte(8'h47);
        expect1("go_ack", 8'h06);
        m_hold = 1'b0;
        check("go_hold", cpu_hold, 0);
        we_before = we_cnt;
        wd.delete();
        wd.push_back(8'h55);
        do_write(16'h0000, 1, wd);
        check("nohold_we", we_cnt, we_before);
        check("nohold_ram0", ram[0], 8'h01);
        do_read(16'h0000, 1);

`ifdef SERIAL_LOADER_CHECKSUM_EN
        send_byte(8'h48);
        m_hold = 1'b1;
        expect1("cs_hold", 8'h06);
        send_byte(8'h57); send_byte(8'h00); send_byte(8'h00); send_byte(8'h02);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'hFD);
        exp_ram[0] = 8'h01; exp_ram[1] = 8'h02;
        expect1("cs_good", 8'h06);
        send_byte(8'h57); send_byte(8'h00); send_byte(8'h00); send_byte(8'h02);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'hFC);
        expect1("cs_bad", 8'h15);
`endif

        // Reset while a write strobe is on the RAM port.
        if (!m_hold) begin
            send_byte(8'h48);
            m_hold = 1'b1;
            expect1("rst_hold", 8'h06);
        end
        send_byte(8'h57); send_byte(8'h00); send_byte(8'h40); send_byte(8'h02);
        send_byte(8'h77);
        check("rst_we_live", mem_we, 1);
        #1 RESET_n = 1'b0;
        #1 check_reset_vals("midrst");
        @(posedge clock);
        #1 check("midrst_ram40", ram[16'h40], exp_ram[16'h40]);
        RESET_n = 1'b1;
        m_hold = 1'b0;
        rxq.delete();
        send_byte(8'h5A);
        expect1("post_rst", 8'h15);

        mism = 0;
        for (int i = 0; i < DEPTH; i++) if (ram[i] !== exp_ram[i]) mism++;
        check("ram_image", mism, 0);
        check("handshake", hs_viol, 0);
        check("we_no_hold", we_viol, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/serial_loader.md
# serial_loader

UART-driven bus initiator for the light8080 SOC: the host-side counterpart of the CPU's IO-mapped UART access. It takes byte commands from the UART receive interface and writes or reads program/data RAM directly, returning responses through the UART transmit interface. A `cpu_hold` output keeps the CPU in reset while the host loads an image. It sits between `uart` and the RAM port, muxed ahead of the CPU's RAM path.

## Interface
- `ADDR_W`, 13, RAM address width; host address bits above this are ignored.
- `TIMEOUT_CYC`, 2700000, inter-byte timeout in clocks, about 100 ms at 27 MHz.
- `HOLD_AT_RESET`, 0, reset value of `cpu_hold`.
- `clock`  in  1  single system clock, rising edge.
- `RESET_n`  in  1  reset; asynchronous, active-low.
- `rx_data`  in  8  received byte from `uart`.
- `rx_valid`  in  1  one-cycle strobe; `rx_data` is valid in this cycle.
- `tx_data`  out  8  byte to transmit.
- `tx_valid`  out  1  one-cycle transmit strobe.
- `tx_busy`  in  1  transmitter busy.
- `mem_addr`  out  ADDR_W  RAM address.
- `mem_we`  out  1  RAM write enable, one cycle per byte.
- `mem_wdata`  out  8  RAM write data.
- `mem_rdata`  in  8  RAM read data; synchronous RAM, valid 1 cycle after the address is driven.
- `cpu_hold`  out  1  1 holds the CPU in reset and grants RAM to this block.
- `busy`  out  1  high whenever state is not IDLE.

## Operation
- **Command frame:** `cmd`, `addr_hi`, `addr_lo`, `len`. `len` = 0 means 256 bytes.
- **`cmd` 0x57 'W':** followed by `len` data bytes. Each data byte is written to RAM as it arrives, then the address increments. After the last byte the block sends ACK 0x06.
- **`cmd` 0x52 'R':** reads `len` bytes starting at the address and transmits each one in turn.
- **`cmd` 0x47 'G':** takes no further bytes. Sends 0x06, then clears `cpu_hold`.
- **`cmd` 0x48 'H':** takes no further bytes. Sets `cpu_hold`, then sends 0x06.
- **Any other `cmd`:** sends NAK 0x15 and returns to IDLE.
- **States:**
  - IDLE → AH (W/R) or ACK (G/H) or NAK (other).
  - AH → AL → LEN.
  - LEN → WDATA or RADDR.
  - WDATA loops until the count is exhausted, then → ACK.
  - RADDR → RWAIT → RSEND. RSEND loops back to RADDR, or goes to IDLE after the last byte.
  - ACK/NAK send their byte, then → IDLE.
- **Address arithmetic:** the address is `{addr_hi, addr_lo}` truncated to ADDR_W bits. It increments modulo 2^ADDR_W, so the top of RAM wraps to 0.
- **Byte counter:** 9 bits, loaded with `len` (0 loads 256).
- **Timeout:** in AH, AL, LEN or WDATA, if no `rx_valid` arrives for TIMEOUT_CYC clocks, return to IDLE silently. Bytes already written stay written.
- **`rx_valid` outside a receiving state** (RADDR, RWAIT, RSEND, ACK, NAK) is dropped.
- **`mem_we`** may assert only while `cpu_hold` = 1. A 'W' or 'R' issued with `cpu_hold` = 0 is answered with NAK once the full frame has been received; W data bytes are consumed and discarded.

## Timing
- **Reset values:** `tx_valid` 0, `tx_data` 0, `mem_we` 0, `mem_addr` 0, `mem_wdata` 0, `busy` 0, `cpu_hold` = HOLD_AT_RESET, state IDLE, counters 0.
- **Write path:** a data byte on `rx_valid` in cycle N drives `mem_we`/`mem_addr`/`mem_wdata` in cycle N+1.
- **Read path:** address driven in RADDR; RAM data sampled in RWAIT.
- **Transmit handshake:** pulse `tx_valid` only when `tx_busy` = 0. After a pulse, ignore `tx_busy` for 1 cycle, then wait for `tx_busy` = 0 before the next pulse.
- **Reset mid-command:** returns to IDLE immediately. No partial `mem_we` is extended.

## Configuration
- **`SERIAL_LOADER_CHECKSUM_EN` defined:**
  - 'W' takes one extra byte after the data. The 8-bit sum of all data bytes plus this byte must equal 0x00; the block then sends 0x06, otherwise 0x15.
  - 'R' transmits one extra byte after the data: the two's complement of the 8-bit data sum.
- **Undefined:** no checksum bytes are sent or expected.

## Structure
- **Shared package `l80_pkg`:** command codes (0x57, 0x52, 0x47, 0x48), ACK/NAK codes, state enum.
- **Sub-module `loader_txq`:** one-byte transmit holding register implementing the `tx_valid`/`tx_busy` handshake; exposes `ready`/`load`.

## Test plan
- **Write then read:** with `cpu_hold` = 1, send 57 00 10 03 AA BB CC. RAM[0x10..0x12] = AA, BB, CC; host receives 06. Then send 52 00 10 03; host receives AA BB CC.
- **Wrap:** send 57 1F FF 02 11 22. RAM[0x1FFF] = 11 and RAM[0x0000] = 22.
- **Full-length read:** send 52 00 00 00; exactly 256 bytes are returned.
- **Errors:** send 5A; host receives 15. Send 57 00 00 02 01, then idle for TIMEOUT_CYC+1 clocks; no response, RAM[0] = 01, `busy` = 0.
- **Hold control:** send 47; host receives 06 and `cpu_hold` falls. A following 57 00 00 01 55 gives 15 with no `mem_we`.
- **Checksum (macro on):** send 57 00 00 02 01 02 FD; host receives 06. Same frame with FC; host receives 15. Assert `RESET_n` low mid-frame; all outputs take their reset values.
